// File: rtl/sram_fifo_ctrl.sv
// sram_fifo_ctrl: FIFO controller over an external 1R1W SRAM.
// Reads prefetch into a 2-entry register buffer for full throughput.
module sram_fifo_ctrl #(
  parameter int DEPTH      = 64,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  sram_wr_enable,
  output logic [ADDR_WIDTH-1:0] sram_wr_addr,
  output logic [DATA_WIDTH-1:0] sram_wr_dataIn,
  output logic                  sram_rd_enable,
  output logic [ADDR_WIDTH-1:0] sram_rd_addr,
  input  logic [DATA_WIDTH-1:0] sram_rd_dataOut
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   sram_cnt_q, sram_cnt_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [1:0]            buf_cnt_q, buf_cnt_d;
  logic                  head_q, head_d;
  logic                  inflight_q, inflight_d;
  logic [DATA_WIDTH-1:0] buf_q [2];
  logic [DATA_WIDTH-1:0] buf_d [2];

  logic       push;
  logic       pop;
  logic       rd_issue;
  logic [1:0] occ;
  logic       wslot;

  // Handshakes and read-issue decision from registered state
  always_comb begin
    in_ready  = resetn && !flush && (count_q < DEPTH_C);
    push      = in_valid && in_ready;
    out_valid = (buf_cnt_q != 2'd0);
    pop       = out_valid && out_ready;
    occ       = buf_cnt_q + {1'b0, inflight_q} - {1'b0, pop};
    rd_issue  = resetn && !flush
                && (sram_cnt_q != '0) && (occ < 2'd2);
    wslot     = head_q ^ buf_cnt_q[0];
  end

  // Port drive: SRAM accesses and output head
  always_comb begin
    sram_wr_enable = push;
    sram_wr_addr   = wr_ptr_q;
    sram_wr_dataIn = in_data;
    sram_rd_enable = rd_issue;
    sram_rd_addr   = rd_ptr_q;
    out_data       = buf_q[head_q];
    count          = count_q;
  end

  // Next-state: pointers, counters, buffer fill; flush clears all
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    sram_cnt_d = sram_cnt_q;
    count_d    = count_q;
    buf_cnt_d  = occ;
    head_d     = head_q ^ pop;
    inflight_d = rd_issue;
    buf_d      = buf_q;
    if (push) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    if (rd_issue) rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
    sram_cnt_d = sram_cnt_q
                 + (ADDR_WIDTH+1)'(push)
                 - (ADDR_WIDTH+1)'(rd_issue);
    count_d    = count_q
                 + (ADDR_WIDTH+1)'(push)
                 - (ADDR_WIDTH+1)'(pop);
    if (inflight_q) buf_d[wslot] = sram_rd_dataOut;
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      sram_cnt_d = '0;
      count_d    = '0;
      buf_cnt_d  = '0;
      head_d     = 1'b0;
      inflight_d = 1'b0;
      buf_d[0]   = '0;
      buf_d[1]   = '0;
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      sram_cnt_q <= '0;
      count_q    <= '0;
      buf_cnt_q  <= '0;
      head_q     <= 1'b0;
      inflight_q <= 1'b0;
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      sram_cnt_q <= sram_cnt_d;
      count_q    <= count_d;
      buf_cnt_q  <= buf_cnt_d;
      head_q     <= head_d;
      inflight_q <= inflight_d;
      buf_q[0]   <= buf_d[0];
      buf_q[1]   <= buf_d[1];
    end
  end

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// tb_sram_fifo_ctrl: directed checks of sram_fifo_ctrl at DEPTH=4
// with a behavioural 1R1W SRAM attached.
module tb_sram_fifo_ctrl;

  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int AW    = 2;

  logic          clock = 1'b0;
  logic          resetn;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW:0]   count;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;

  logic [DW-1:0] mem [DEPTH];

  int passed = 0;
  int total  = 0;
  int coll   = 0;
  int gated  = 0;

  logic [DW-1:0] q [$];
  logic [DW-1:0] exp_d;

  always #5 clock = ~clock;

  sram_fifo_ctrl #(
    .DEPTH(DEPTH),
    .DATA_WIDTH(DW)
  ) dut (
    .clock(clock),
    .resetn(resetn),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .count(count),
    .sram_wr_enable(wr_en),
    .sram_wr_addr(wr_addr),
    .sram_wr_dataIn(wr_data),
    .sram_rd_enable(rd_en),
    .sram_rd_addr(rd_addr),
    .sram_rd_dataOut(rd_data)
  );

  always @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

  always @(negedge clock) begin
    if (wr_en && rd_en && wr_addr == rd_addr) coll++;
    if ((!resetn || flush) && (wr_en || rd_en)) gated++;
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic pop_expect(input logic [DW-1:0] exp,
                            input string tag);
    int n = 0;
    out_ready = 1'b1;
    #2;
    while (!out_valid && n < 10) begin
      tick();
      #1;
      n++;
    end
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_data"}, out_data, exp);
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rd_data   = '0;
    resetn    = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h55;
    out_ready = 1'b1;
    #12;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
    tick();
    tick();

    // latency: push A1 into empty controller
    resetn    = 1'b1;
    out_ready = 1'b0;
    in_data   = 32'hA1;
    #2;
    chk("lat_c0_ready", {31'd0, in_ready}, 32'd1);
    chk("lat_c0_wr_en", {31'd0, wr_en}, 32'd1);
    chk("lat_c0_wr_addr", {30'd0, wr_addr}, 32'd0);
    chk("lat_c0_wr_data", wr_data, 32'hA1);
    tick();
    in_valid = 1'b0;
    #2;
    chk("lat_c1_count", {29'd0, count}, 32'd1);
    chk("lat_c1_rd_en", {31'd0, rd_en}, 32'd1);
    chk("lat_c1_rd_addr", {30'd0, rd_addr}, 32'd0);
    chk("lat_c1_valid", {31'd0, out_valid}, 32'd0);
    tick();
    #2;
    chk("lat_c2_valid", {31'd0, out_valid}, 32'd0);
    chk("lat_c2_count", {29'd0, count}, 32'd1);
    tick();
    #2;
    chk("lat_c3_valid", {31'd0, out_valid}, 32'd1);
    chk("lat_c3_data", out_data, 32'hA1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    #2;
    chk("lat_c4_count", {29'd0, count}, 32'd0);
    chk("lat_c4_valid", {31'd0, out_valid}, 32'd0);

    // fill to full with out_ready low
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h10 + i;
      #2;
      chk("fill_ready", {31'd0, in_ready}, 32'd1);
      tick();
    end
    in_data = 32'h14;
    #2;
    chk("full_ready", {31'd0, in_ready}, 32'd0);
    chk("full_count", {29'd0, count}, 32'd4);
    tick();
    out_ready = 1'b1;
    #2;
    chk("full_pop_ready", {31'd0, in_ready}, 32'd0);
    chk("full_pop_data", out_data, 32'h10);
    tick();
    out_ready = 1'b0;
    #2;
    chk("after_pop_ready", {31'd0, in_ready}, 32'd1);
    chk("after_pop_count", {29'd0, count}, 32'd3);
    tick();
    in_valid = 1'b0;
    #2;
    chk("refill_count", {29'd0, count}, 32'd4);
    for (int i = 1; i < 5; i++)
      pop_expect(32'h10 + i, "drain");
    #2;
    chk("drain_count", {29'd0, count}, 32'd0);

    // streaming 0..19 with both sides always ready
    for (int k = 0; k < 23; k++) begin
      in_valid  = (k < 20);
      in_data   = k;
      out_ready = 1'b1;
      #2;
      if (k < 20)
        chk("strm_ready", {31'd0, in_ready}, 32'd1);
      chk("strm_count", {29'd0, count},
          ((k < 20) ? k : 20) - ((k > 3) ? k - 3 : 0));
      if (k >= 3) begin
        chk("strm_valid", {31'd0, out_valid}, 32'd1);
        chk("strm_data", out_data, k - 3);
      end
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #2;
    chk("strm_end_count", {29'd0, count}, 32'd0);
    chk("strm_end_valid", {31'd0, out_valid}, 32'd0);
    tick();

    // flush with 3 entries and a read in flight
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 32'hC0 + i;
      tick();
    end
    flush = 1'b1;
    in_data = 32'hCF;
    #2;
    chk("fl_count_pre", {29'd0, count}, 32'd3);
    chk("fl_ready", {31'd0, in_ready}, 32'd0);
    chk("fl_wr_en", {31'd0, wr_en}, 32'd0);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    #2;
    chk("fl_count", {29'd0, count}, 32'd0);
    chk("fl_valid", {31'd0, out_valid}, 32'd0);
    tick();
    in_valid = 1'b1;
    in_data  = 32'hD0;
    #2;
    chk("fl_wr_addr", {30'd0, wr_addr}, 32'd0);
    tick();
    in_valid = 1'b0;
    pop_expect(32'hD0, "fl_next");
    #2;
    chk("fl_empty", {29'd0, count}, 32'd0);

    // reset mid-stream
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 32'hE0 + i;
      tick();
    end
    resetn = 1'b0;
    #2;
    chk("mr_ready", {31'd0, in_ready}, 32'd0);
    chk("mr_valid", {31'd0, out_valid}, 32'd0);
    chk("mr_data", out_data, 32'd0);
    chk("mr_count", {29'd0, count}, 32'd0);
    chk("mr_rd_en", {31'd0, rd_en}, 32'd0);
    tick();
    resetn  = 1'b1;
    in_data = 32'hF0;
    #2;
    chk("mr_wr_addr", {30'd0, wr_addr}, 32'd0);
    chk("mr_wr_en", {31'd0, wr_en}, 32'd1);
    tick();
    in_valid = 1'b0;
    pop_expect(32'hF0, "mr_next");

    // random traffic against a reference queue
    q.delete();
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 1) != 0);
      in_data   = $urandom;
      #2;
      chk("rnd_count", {29'd0, count}, q.size());
      chk("rnd_ready", {31'd0, in_ready},
          {31'd0, (q.size() < DEPTH)});
      if (out_valid && out_ready) begin
        exp_d = (q.size() > 0) ? q.pop_front() : 32'hDEADBEEF;
        chk("rnd_data", out_data, exp_d);
      end
      if (in_valid && in_ready) q.push_back(in_data);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #2;

    chk("no_collision", coll, 32'd0);
    chk("gated_access", gated, 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
